uart_point_decoder: RTL and testbench

Downstream stage of the UART receiver in the vector display path. Takes the receiver's byte strobe and byte, hunts for a frame marker, assembles 4-byte point packets into 12-bit X/Y coordinates plus an 8-bit colour, and queues them with frame markers in order in a small first-word-fall-through FIFO. The vector drawing engine drains the FIFO with a valid/ready handshake. A partial packet is discarded after an inter-byte timeout.

---
 rtl/uart_point_decoder.sv | 141 ++++++++++++++
 tb/tb_uart_point_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_point_decoder.sv
// Byte-stream decoder for the vector display path: hunts for a 4x0x00 frame marker, then packs
// 4-byte words into {frame, x, y, color} entries queued in a first-word-fall-through FIFO.
module uart_point_decoder #(
    parameter int FIFO_DEPTH   = 16,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Pt_Valid,
    input  logic        i_Pt_Ready,
    output logic        o_Pt_Frame,
    output logic [11:0] o_Pt_X,
    output logic [11:0] o_Pt_Y,
    output logic [7:0]  o_Pt_Color,
    output logic        o_Locked,
    output logic        o_Overflow
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [15:0] TCNT_MAX = 16'(TIMEOUT_CLKS - 1);
    localparam logic [32:0] MARKER   = {1'b1, 32'd0};

    typedef enum logic {S_HUNT, S_LOCKED} state_t;

    state_t      state_q, state_d;
    logic [1:0]  zcnt_q, zcnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] bytes_q, bytes_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        push;
    logic [32:0] push_data;
    logic [31:0] word;

    // The first three bytes live in bytes_q; the fourth is taken straight off the bus.
    assign word = {bytes_q, i_Rx_Byte};

    always_comb begin
        state_d   = state_q;
        zcnt_d    = zcnt_q;
        idx_d     = idx_q;
        bytes_d   = bytes_q;
        tcnt_d    = tcnt_q;
        push      = 1'b0;
        push_data = '0;
        if (i_Rx_DV) begin
            tcnt_d = '0;
        end
        case (state_q)
            S_HUNT: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte != 8'h00) begin
                        zcnt_d = 2'd0;
                    end else if (zcnt_q == 2'd3) begin
                        push      = 1'b1;
                        push_data = MARKER;
                        state_d   = S_LOCKED;
                        idx_d     = 2'd0;
                        zcnt_d    = 2'd0;
                    end else begin
                        zcnt_d = zcnt_q + 2'd1;
                    end
                end
            end
            S_LOCKED: begin
                if (i_Rx_DV) begin
                    bytes_d = {bytes_q[15:0], i_Rx_Byte};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        push      = 1'b1;
                        push_data = (word == 32'd0) ? MARKER : {1'b0, word};
                    end
                end else if (idx_q != 2'd0) begin
                    // A strobe in the expiry cycle wins because this branch only runs without one.
                    if (tcnt_q == TCNT_MAX) begin
                        state_d = S_HUNT;
                        idx_d   = 2'd0;
                        zcnt_d  = 2'd0;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase
    end

    logic [32:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        overflow_q;
    logic        full, empty, pop, wr_en;
    logic [32:0] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && i_Pt_Ready;
    // A simultaneous pop frees the slot the push lands in, so only full-without-pop drops.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= S_HUNT;
            zcnt_q     <= '0;
            idx_q      <= '0;
            bytes_q    <= '0;
            tcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            zcnt_q  <= zcnt_d;
            idx_q   <= idx_d;
            bytes_q <= bytes_d;
            tcnt_q  <= tcnt_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !wr_en) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign {o_Pt_Frame, o_Pt_X, o_Pt_Y, o_Pt_Color} = head;
    assign o_Pt_Valid = !empty;
    assign o_Locked   = (state_q == S_LOCKED);
    assign o_Overflow = overflow_q;
endmodule

// File: tb/tb_uart_point_decoder.sv
// Self-checking bench: vector table of 4-byte words plus hand sequences for hunt, timeout,
// overflow and reset; expected FIFO entries are queued on drive and compared on each pop.
module tb_uart_point_decoder;
    localparam int          DEPTH  = 4;
    localparam int          TMO    = 20;
    localparam int          NV     = 9;
    localparam logic [32:0] MARKER = {1'b1, 32'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        pt_valid, pt_ready, pt_frame, locked, overflow;
    logic [11:0] pt_x, pt_y;
    logic [7:0]  pt_color;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;

    typedef struct {
        logic [31:0] word;
        logic [32:0] exp;
    } vec_t;
    vec_t vecs [NV];

    uart_point_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock   (clk),
        .i_Reset   (rst),
        .i_Rx_DV   (rx_dv),
        .i_Rx_Byte (rx_byte),
        .o_Pt_Valid(pt_valid),
        .i_Pt_Ready(pt_ready),
        .o_Pt_Frame(pt_frame),
        .o_Pt_X    (pt_x),
        .o_Pt_Y    (pt_y),
        .o_Pt_Color(pt_color),
        .o_Locked  (locked),
        .o_Overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Each consumed head entry is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && pt_valid && pt_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL pop_unexpected: got %0h, expected no entry",
                         {pt_frame, pt_x, pt_y, pt_color});
            end else begin
                mon_exp = exp_q.pop_front();
                $display("[TB] pop frame=%0b x=%03h y=%03h c=%02h", pt_frame, pt_x, pt_y, pt_color);
                chk("pop", 64'({pt_frame, pt_x, pt_y, pt_color}), 64'(mon_exp));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
        end
    endtask

    task automatic lock_up(input bit expect_marker);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && expect_marker) exp_q.push_back(MARKER);
            send_byte(8'h00);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle(1);
        chk(name, 64'(exp_q.size()), 64'd0);
        chk({name, "_empty"}, 64'(pt_valid), 64'd0);
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_valid"}, 64'(pt_valid), 64'd0);
        chk({name, "_head"}, 64'({pt_frame, pt_x, pt_y, pt_color}), 64'd0);
        chk({name, "_locked"}, 64'(locked), 64'd0);
        chk({name, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h00000000, MARKER};
        vecs[1] = '{32'h01020304, {1'b0, 12'h010, 12'h203, 8'h04}};
        vecs[2] = '{32'h02040608, {1'b0, 12'h020, 12'h406, 8'h08}};
        vecs[3] = '{32'h01010101, {1'b0, 12'h010, 12'h101, 8'h01}};
        vecs[4] = '{32'hAABBCCDD, {1'b0, 12'hAAB, 12'hBCC, 8'hDD}};
        vecs[5] = '{32'hFFFFFFFF, {1'b0, 12'hFFF, 12'hFFF, 8'hFF}};
        vecs[6] = '{32'h00000001, {1'b0, 12'h000, 12'h000, 8'h01}};
        vecs[7] = '{32'h80000000, {1'b0, 12'h800, 12'h000, 8'h00}};
        vecs[8] = '{32'h00F00000, {1'b0, 12'h00F, 12'h000, 8'h00}};

        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; pt_ready = 1'b0;
        idle(2);
        chk_zero_outputs("in_reset");
        rst = 1'b0;
        idle(1);
        chk_zero_outputs("after_reset");

        // Lock, then stream the vector table with the consumer always ready.
        pt_ready = 1'b1;
        lock_up(1'b1);
        chk("lock_after_4_zeros", 64'(locked), 64'd1);
        for (int i = 0; i < NV; i++) begin
            exp_q.push_back(vecs[i].exp);
            send_word(vecs[i].word);
        end
        drain("table");

        // Partial packet timeout: still locked one clock before expiry, unlocked at it.
        send_byte(8'h11);
        send_byte(8'h22);
        idle(TMO - 1);
        chk("tmo_not_yet", 64'(locked), 64'd1);
        idle(1);
        chk("tmo_unlock", 64'(locked), 64'd0);
        chk("tmo_no_entry", 64'(pt_valid), 64'd0);

        // Hunt rejection: a nonzero byte restarts the zero count.
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("hunt_reject_unlocked", 64'(locked), 64'd0);
        exp_q.push_back(MARKER);
        send_byte(8'h00);
        chk("hunt_relock", 64'(locked), 64'd1);
        exp_q.push_back(vecs[4].exp);
        send_word(vecs[4].word);
        drain("hunt");

        // Strobe arriving in the exact cycle the timeout would fire.
        send_byte(8'h11);
        send_byte(8'h22);
        idle(TMO - 1);
        send_byte(8'h33);
        chk("tmo_strobe_wins", 64'(locked), 64'd1);
        exp_q.push_back({1'b0, 12'h112, 12'h233, 8'h44});
        send_byte(8'h44);
        drain("tmo_strobe");

        // Overflow: consumer stalled, frame plus four points into a 4-deep FIFO.
        rst = 1'b1; idle(1); rst = 1'b0;
        pt_ready = 1'b0;
        lock_up(1'b1);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(vecs[i].exp);
            send_word(vecs[i].word);
        end
        chk("full_no_overflow_yet", 64'(overflow), 64'd0);
        send_word(vecs[4].word);
        chk("overflow_set", 64'(overflow), 64'd1);
        chk("overflow_head_frame", 64'({pt_valid, pt_frame}), 64'd3);
        chk("overflow_still_locked", 64'(locked), 64'd1);
        pt_ready = 1'b1;
        drain("overflow");
        chk("overflow_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset mid-packet with a non-empty FIFO.
        pt_ready = 1'b0;
        send_word(vecs[1].word);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("pre_reset_state", 64'({pt_valid, locked, overflow, pt_x}), 64'({3'b111, 12'h010}));
        #2;
        rst = 1'b1;
        #1;
        chk_zero_outputs("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full FIFO with a pop and a push in the same cycle: nothing is dropped.
        lock_up(1'b1);
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(vecs[i].exp);
            send_word(vecs[i].word);
        end
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        exp_q.push_back(vecs[4].exp);
        pt_ready = 1'b1;
        send_byte(8'hDD);
        drain("full_pop_push");
        chk("full_pop_push_no_overflow", 64'(overflow), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
